// File: rtl/mem_pkg.sv
// Shared types and widths for the memory-side controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mdr_reg.sv
// Memory data register: 32-bit register with a bus load and a memory capture source.
// Latency: one clock from load strobe to q.
// Backpressure: none; memory capture wins over a bus load on the same edge.
//
// Ports: clock, clear (sync active-low), load_bus/bus_data (datapath load),
//        load_mem/mem_data (RAM capture), q (register contents).
module mdr_reg
    import mem_pkg::*;
(
    input  logic              clock,
    input  logic              clear,
    input  logic              load_bus,
    input  logic [DATA_W-1:0] bus_data,
    input  logic              load_mem,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clock) begin
        if (!clear) begin
            q <= '0;
        end else if (load_mem) begin
            q <= mem_data;
        end else if (load_bus) begin
            q <= bus_data;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: holds MAR/MDR and turns request pulses into held RAM read/write strobes.
// Latency: request to mem_done is WAIT_STATES+2 cycles; strobe held WAIT_STATES+1 cycles.
// Backpressure: mem_busy high in RD/WR; requests outside IDLE are dropped, not queued.
//
// Ports: clock, clear (sync active-low), BusMuxOut/MARin/MDRin (datapath loads),
//        mem_rd/mem_wr (request pulses), Mdatain (RAM data), ram_read/ram_write/
//        ram_address/ram_wdata (RAM side), MDRout_data, mem_busy, mem_done, mem_err.
// Optional: define MEM_ERR_EN to build the sticky protocol-error flag on mem_err.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [DATA_W-1:0] Mdatain,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [DATA_W-1:0] MDRout_data,
    output logic              mem_busy,
    output logic              mem_done,
    output logic              mem_err
);

    localparam logic [CNT_W-1:0] WS_CNT = CNT_W'(WAIT_STATES);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic              mdr_cap;
    logic              in_access;
    logic              can_load;

    // Address and write data are frozen while a strobe is active.
    assign in_access = (state == RD) || (state == WR);
    assign can_load  = !in_access;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mdr_cap   = 1'b0;
        case (state)
            IDLE: begin
                // Write takes priority when both requests arrive together.
                if (mem_wr) begin
                    state_nxt = WR;
                    cnt_nxt   = WS_CNT;
                end else if (mem_rd) begin
                    state_nxt = RD;
                    cnt_nxt   = WS_CNT;
                end
            end
            RD: begin
                if (cnt == '0) begin
                    mdr_cap   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            WR: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes and status are flops decoded from the next state, so they are
    // glitch-free and line up exactly with the state register.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state     <= IDLE;
            cnt       <= '0;
            mar       <= '0;
            ram_read  <= 1'b0;
            ram_write <= 1'b0;
            mem_busy  <= 1'b0;
            mem_done  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            ram_read  <= (state_nxt == RD);
            ram_write <= (state_nxt == WR);
            mem_busy  <= (state_nxt == RD) || (state_nxt == WR);
            mem_done  <= (state_nxt == DONE);
            if (MARin && can_load) begin
                mar <= BusMuxOut[ADDR_W-1:0];
            end
        end
    end

    mdr_reg u_mdr (
        .clock    (clock),
        .clear    (clear),
        .load_bus (MDRin && can_load),
        .bus_data (BusMuxOut),
        .load_mem (mdr_cap),
        .mem_data (Mdatain),
        .q        (mdr)
    );

    assign ram_address = mar;
    assign ram_wdata   = mdr;
    assign MDRout_data = mdr;

`ifdef MEM_ERR_EN
    logic err_q;
    logic err_set;

    assign err_set = ((mem_rd || mem_wr) && (state != IDLE))
                   || (mem_rd && mem_wr)
                   || ((MARin || MDRin) && in_access);

    always_ff @(posedge clock) begin
        if (!clear) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign mem_err = err_q;
`else
    assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: three instances (WAIT_STATES 0, 3, 2) share stimulus,
// each with its own RAM model; immediate assertions compare against hand-derived values.
// Index 0 = WAIT_STATES 0, index 1 = WAIT_STATES 3, index 2 = WAIT_STATES 2.
module tb_mem_ctrl;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic [31:0] BusMuxOut = '0;
    logic        MARin = 1'b0;
    logic        MDRin = 1'b0;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;

    logic [31:0] mdatain_o [3];
    logic        ram_read_o [3];
    logic        ram_write_o [3];
    logic [8:0]  addr_o [3];
    logic [31:0] wdata_o [3];
    logic [31:0] mdr_o [3];
    logic        busy_o [3];
    logic        done_o [3];
    logic        err_o [3];

    logic [31:0] ram0 [512];
    logic [31:0] ram1 [512];
    logic [31:0] ram2 [512];
    logic        pre_en = 1'b0;
    logic [8:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    int vectors = 0;
    int fails = 0;
    int rd_cnt [3];
    int wr_cnt [3];
    int done_at [3];
    logic [31:0] mdr_done [3];
    logic [8:0]  strobe_addr [3];
    logic        exp_err;

    always #5 clock = ~clock;

    mem_ctrl #(.WAIT_STATES(0)) u0 (
        .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut), .MARin(MARin), .MDRin(MDRin),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .Mdatain(mdatain_o[0]),
        .ram_read(ram_read_o[0]), .ram_write(ram_write_o[0]), .ram_address(addr_o[0]),
        .ram_wdata(wdata_o[0]), .MDRout_data(mdr_o[0]), .mem_busy(busy_o[0]),
        .mem_done(done_o[0]), .mem_err(err_o[0]));

    mem_ctrl #(.WAIT_STATES(3)) u3 (
        .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut), .MARin(MARin), .MDRin(MDRin),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .Mdatain(mdatain_o[1]),
        .ram_read(ram_read_o[1]), .ram_write(ram_write_o[1]), .ram_address(addr_o[1]),
        .ram_wdata(wdata_o[1]), .MDRout_data(mdr_o[1]), .mem_busy(busy_o[1]),
        .mem_done(done_o[1]), .mem_err(err_o[1]));

    mem_ctrl #(.WAIT_STATES(2)) u2 (
        .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut), .MARin(MARin), .MDRin(MDRin),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .Mdatain(mdatain_o[2]),
        .ram_read(ram_read_o[2]), .ram_write(ram_write_o[2]), .ram_address(addr_o[2]),
        .ram_wdata(wdata_o[2]), .MDRout_data(mdr_o[2]), .mem_busy(busy_o[2]),
        .mem_done(done_o[2]), .mem_err(err_o[2]));

    // RAM models: asynchronous read, write on the clock edge while the strobe is high.
    assign mdatain_o[0] = ram0[addr_o[0]];
    assign mdatain_o[1] = ram1[addr_o[1]];
    assign mdatain_o[2] = ram2[addr_o[2]];

    always @(posedge clock) begin
        if (pre_en) begin
            ram0[pre_addr] <= pre_data;
            ram1[pre_addr] <= pre_data;
            ram2[pre_addr] <= pre_data;
        end else begin
            if (ram_write_o[0]) ram0[addr_o[0]] <= wdata_o[0];
            if (ram_write_o[1]) ram1[addr_o[1]] <= wdata_o[1];
            if (ram_write_o[2]) ram2[addr_o[2]] <= wdata_o[2];
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        clear = 1'b0;
        tick();
        clear = 1'b1;
    endtask

    task automatic preload(input logic [8:0] a, input logic [31:0] d);
        pre_en = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic load_mar(input logic [31:0] v);
        MARin = 1'b1;
        BusMuxOut = v;
        tick();
        MARin = 1'b0;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        MDRin = 1'b1;
        BusMuxOut = v;
        tick();
        MDRin = 1'b0;
    endtask

    // Sample index 0 is the cycle right after the request edge.
    task automatic watch(input int n, input int mar_at, input int clr_at);
        for (int k = 0; k < 3; k++) begin
            rd_cnt[k] = 0;
            wr_cnt[k] = 0;
            done_at[k] = -1;
            mdr_done[k] = '0;
            strobe_addr[k] = '1;
        end
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 3; k++) begin
                if (ram_read_o[k]) rd_cnt[k]++;
                if (ram_write_o[k]) wr_cnt[k]++;
                if (ram_read_o[k] || ram_write_o[k]) strobe_addr[k] = addr_o[k];
                if (done_o[k] && done_at[k] < 0) begin
                    done_at[k] = i;
                    mdr_done[k] = mdr_o[k];
                end
            end
            if (i == mar_at) begin
                MARin = 1'b1;
                BusMuxOut = 32'h0000_00AA;
            end
            if (i == clr_at) clear = 1'b0;
            tick();
            MARin = 1'b0;
            clear = 1'b1;
        end
    endtask

    initial begin
`ifdef MEM_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        // Reset with random inputs on the bus and control pins.
        clear = 1'b0;
        for (int i = 0; i < 2; i++) begin
            BusMuxOut = $urandom;
            MARin = 1'($urandom_range(0, 1));
            MDRin = 1'($urandom_range(0, 1));
            mem_rd = 1'($urandom_range(0, 1));
            mem_wr = 1'($urandom_range(0, 1));
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            check("rst_read", 32'(ram_read_o[k]), 32'd0);
            check("rst_write", 32'(ram_write_o[k]), 32'd0);
            check("rst_addr", 32'(addr_o[k]), 32'd0);
            check("rst_wdata", wdata_o[k], 32'd0);
            check("rst_mdr", mdr_o[k], 32'd0);
            check("rst_busy", 32'(busy_o[k]), 32'd0);
            check("rst_done", 32'(done_o[k]), 32'd0);
            check("rst_err", 32'(err_o[k]), 32'd0);
        end
        BusMuxOut = '0;
        MARin = 1'b0;
        MDRin = 1'b0;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        clear = 1'b1;
        tick();

        // Write 0xDEADBEEF to 0x005, zero wait states.
        preload(9'h005, 32'h0);
        load_mar(32'h0000_0005);
        load_mdr(32'hDEAD_BEEF);
        mem_wr = 1'b1;
        tick();
        mem_wr = 1'b0;
        watch(8, -1, -1);
        check("wr0_strobe_len", 32'(wr_cnt[0]), 32'd1);
        check("wr0_no_read", 32'(rd_cnt[0]), 32'd0);
        check("wr0_done_at", 32'(done_at[0]), 32'd1);
        check("wr0_addr", 32'(strobe_addr[0]), 32'h005);
        check("wr0_ram", ram0[9'h005], 32'hDEAD_BEEF);
        check("wr3_strobe_len", 32'(wr_cnt[1]), 32'd4);
        check("wr3_done_at", 32'(done_at[1]), 32'd4);

        // Clear MDR then read back.
        load_mdr(32'h0);
        check("mdr_cleared", mdr_o[0], 32'h0);
        mem_rd = 1'b1;
        tick();
        mem_rd = 1'b0;
        watch(8, -1, -1);
        check("rd0_strobe_len", 32'(rd_cnt[0]), 32'd1);
        check("rd0_done_at", 32'(done_at[0]), 32'd1);
        check("rd0_mdr", mdr_done[0], 32'hDEAD_BEEF);

        // Three wait states, read of 0x1FF.
        do_reset();
        preload(9'h1FF, 32'h1234_5678);
        load_mar(32'h0000_01FF);
        mem_rd = 1'b1;
        tick();
        mem_rd = 1'b0;
        watch(10, -1, -1);
        check("rd3_strobe_len", 32'(rd_cnt[1]), 32'd4);
        check("rd3_done_at", 32'(done_at[1]), 32'd4);
        check("rd3_mdr_at_done", mdr_done[1], 32'h1234_5678);
        check("rd3_mdr_after", mdr_o[1], 32'h1234_5678);

        // Both requests plus a MAR load on the same edge: write wins at the new address.
        do_reset();
        preload(9'h010, 32'h0);
        load_mdr(32'hA5A5_A5A5);
        MARin = 1'b1;
        BusMuxOut = 32'h0000_0010;
        mem_rd = 1'b1;
        mem_wr = 1'b1;
        tick();
        MARin = 1'b0;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        watch(8, -1, -1);
        check("both_no_read", 32'(rd_cnt[0]), 32'd0);
        check("both_write_len", 32'(wr_cnt[0]), 32'd1);
        check("both_addr", 32'(strobe_addr[0]), 32'h010);
        check("both_ram", ram0[9'h010], 32'hA5A5_A5A5);
        check("both_err", 32'(err_o[0]), 32'(exp_err));

        // MAR load attempted mid-write with two wait states is ignored.
        do_reset();
        preload(9'h030, 32'h0);
        preload(9'h0AA, 32'h0);
        load_mar(32'h0000_0030);
        load_mdr(32'hCAFE_F00D);
        mem_wr = 1'b1;
        tick();
        mem_wr = 1'b0;
        watch(10, 0, -1);
        check("marmid_write_len", 32'(wr_cnt[2]), 32'd3);
        check("marmid_strobe_addr", 32'(strobe_addr[2]), 32'h030);
        check("marmid_addr_after", 32'(addr_o[2]), 32'h030);
        check("marmid_ram_orig", ram2[9'h030], 32'hCAFE_F00D);
        check("marmid_ram_other", ram2[9'h0AA], 32'h0);
        check("marmid_err", 32'(err_o[2]), 32'(exp_err));

        // Reset in the second strobe cycle of a three-wait-state read.
        do_reset();
        load_mdr(32'h1111_2222);
        load_mar(32'h0000_01FF);
        mem_rd = 1'b1;
        tick();
        mem_rd = 1'b0;
        watch(10, -1, 1);
        check("clrmid_read_len", 32'(rd_cnt[1]), 32'd2);
        check("clrmid_no_done", 32'(done_at[1]), 32'hFFFF_FFFF);
        check("clrmid_mdr", mdr_o[1], 32'h0);
        check("clrmid_busy", 32'(busy_o[1]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
